mc_state_sequencer: RTL and testbench
=====================================

Name: mc_state_sequencer

Overview:
Next-state sequencer for the multi-cycle MIPS datapath. It holds the 4-bit current_state register that feeds the combinational control decoder directly downstream, which maps each state to PCWrite, IRWrite, ALUsrcB and the other datapath controls. Transitions depend on the IR opcode and a memory-ready handshake. It also provides instruction-completion signalling, a retired-instruction counter, and trap/halt status.

Parameters:
COUNT_W, 32, width of the retired-instruction counter.
TIMEOUT, 255, maximum number of cycles to wait for mem_ready in states 3 and 5. A value of 0 disables the timeout.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
opcode  input  6  IR[31:26]; stable from state 1 until the next state 0.
mem_ready  input  1  memory has completed the access in states 3 and 5.
current_state  output  4  registered state, driven to the control decoder.
instr_done  output  1  one-cycle pulse: an instruction has retired.
instr_count  output  COUNT_W  number of retired instructions.
illegal  output  1  sticky flag: an undefined opcode was decoded.
halted  output  1  sticky flag: the sequencer is parked in state 15.

Behaviour:
- Reset (async, rst_n=0): current_state=0, instr_done=0, instr_count=0, illegal=0, halted=0, wait counter=0. On release, the first rising edge evaluates state 0.
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, J=000010. All others are illegal.
- Transitions (one per clock unless a wait is noted):
  - S0 FETCH -> S1, unconditionally, in one cycle. S0 must never stall, because PCWrite and IRWrite are asserted in every S0 cycle.
  - S1 DECODE -> S2 for LW or SW; S6 for R; S8 for BEQ; S9 for J. An illegal opcode is handled per the optional feature.
  - S2 MEMADDR -> S3 for LW; S5 for SW.
  - S3 MEMREAD: stay while mem_ready=0; -> S4 when mem_ready=1.
  - S4 MEMWB -> S0 (retire).
  - S5 MEMWRITE: stay while mem_ready=0; -> S0 (retire) when mem_ready=1.
  - S6 EXEC -> S7. S7 RWB -> S0 (retire). S8 BRANCH -> S0 (retire). S9 JUMP -> S0 (retire).
  - S15 HALT: stays in S15 until reset; halted=1.
  - S10-S14 are unreachable. If entered, go to S15 and set illegal=1.
- Wait timeout:
  - The counter clears on entry to S3 or S5 and increments each cycle spent waiting.
  - If TIMEOUT>0 and the counter reaches TIMEOUT with mem_ready still 0, the next state is S15 and halted is set. illegal is unchanged.
  - If mem_ready=1 arrives in the same cycle the counter reaches TIMEOUT, mem_ready wins and the state advances normally.
- Retire:
  - On a transition into S0 from S4, S5, S7, S8 or S9, instr_done=1 for exactly the first S0 cycle.
  - instr_count increments on that same edge, so the new value is visible alongside the pulse.
  - instr_count wraps modulo 2^COUNT_W with no flag.
- Outputs are registered only, with no combinational path from any input to any output.
- Reset asserted mid-instruction, including during a wait or in S15, returns everything to reset values immediately.

Optional Feature:
Macro: ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in S1 -> S15. illegal=1 and halted=1 on that edge; no retire pulse.
- Not defined: an illegal opcode in S1 -> S0, treated as a NOP (PC was already advanced in S0). instr_done pulses, instr_count increments, and illegal is set and stays set. The S15 path remains for timeouts and S10-S14.

Test Plan:
- Reset, then R-type (opcode 000000), mem_ready=1 -> states 0,1,6,7,0. instr_done pulses in the 5th cycle; instr_count=1.
- LW with mem_ready low for 3 cycles in S3 -> states 0,1,2,3,3,3,3,4,0 (S3 for 4 cycles). Retire once; S0 is never repeated back to back.
- Sequence of SW, BEQ, J, with mem_ready=1 -> state sequences 0,1,2,5 / 0,1,8 / 0,1,9, then back to 0. instr_count=3 at the end.
- Opcode 111111 -> with ILLEGAL_TRAP_EN: S15 after S1, illegal=1, halted=1, count unchanged. Without the macro: back to S0, illegal=1, count+1.
- TIMEOUT=4, SW with mem_ready held at 0 -> S15 after 4 wait cycles, halted=1, illegal=0. Asserting rst_n=0 while in S15 -> state 0 and all flags clear asynchronously.
- COUNT_W=4, run 17 J instructions -> instr_count wraps to 1.

Source files
------------

// File: rtl/mc_state_sequencer.sv
// Next-state sequencer for the multi-cycle MIPS datapath, with retire pulse, retired-instruction count and trap/halt flags.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal opcode traps to HALT instead of retiring as a NOP).
module mc_state_sequencer #(
    parameter int COUNT_W = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic [3:0]         current_state,
    output logic               instr_done,
    output logic [COUNT_W-1:0] instr_count,
    output logic               illegal,
    output logic               halted
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC     = 4'd6,
        S_RWB      = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam int              WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    // Handshake: mem_ready is sampled only in MEMREAD/MEMWRITE; a high sample on a
    // rising edge completes the access and advances the state, low keeps waiting.
    state_t              r_state;
    state_t              w_next;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_done;
    logic [COUNT_W-1:0]  r_count;
    logic                r_illegal;
    logic                r_halted;
    logic                w_retire;
    logic                w_set_illegal;
    logic                w_wait_clr;
    logic                w_wait_inc;
    logic                w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_done    <= 1'b0;
            r_count   <= '0;
            r_illegal <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_done    <= w_retire;
            r_illegal <= r_illegal | w_set_illegal;
            r_halted  <= r_halted | (w_next == S_HALT);
            if (w_retire)
                r_count <= r_count + COUNT_W'(1);
            if (w_wait_clr)
                r_wait <= '0;
            else if (w_wait_inc)
                r_wait <= r_wait + WAIT_W'(1);
        end
    end

    always_comb begin
        w_next        = r_state;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        w_wait_clr    = 1'b0;
        w_wait_inc    = 1'b0;
        // Last permitted wait cycle; a simultaneous mem_ready still wins.
        w_timeout     = (TIMEOUT > 0) && (r_wait == WAIT_LAST);
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:         w_next = S_EXEC;
                    OP_LW, OP_SW: w_next = S_MEMADDR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    default: begin
                        w_set_illegal = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                        w_next        = S_HALT;
`else
                        // PC already advanced in FETCH, so retire as a NOP.
                        w_next        = S_FETCH;
                        w_retire      = 1'b1;
`endif
                    end
                endcase
            end
            S_MEMADDR: begin
                w_wait_clr = 1'b1;
                w_next     = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                if (mem_ready)
                    w_next = S_MEMWB;
                else if (w_timeout)
                    w_next = S_HALT;
                else
                    w_wait_inc = 1'b1;
            end
            S_MEMWRITE: begin
                if (mem_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            S_EXEC: w_next = S_RWB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_HALT: w_next = S_HALT;
            default: begin
                w_next        = S_HALT;
                w_set_illegal = 1'b1;
            end
        endcase
    end

    assign current_state = r_state;
    assign instr_done    = r_done;
    assign instr_count   = r_count;
    assign illegal       = r_illegal;
    assign halted        = r_halted;

endmodule

// File: tb/tb_mc_state_sequencer.sv
// Directed bench for mc_state_sequencer with COUNT_W=4 and TIMEOUT=4; expectations are hand-derived per step.
module tb_mc_state_sequencer;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [3:0] current_state;
    logic       instr_done;
    logic [3:0] instr_count;
    logic       illegal;
    logic       halted;

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0] exp_count;
    logic       exp_illegal;
    logic       exp_halted;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    mc_state_sequencer #(.COUNT_W(4), .TIMEOUT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .current_state (current_state),
        .instr_done    (instr_done),
        .instr_count   (instr_count),
        .illegal       (illegal),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] es, input logic ed);
        chk({tag, ".state"},   {28'd0, current_state}, {28'd0, es});
        chk({tag, ".done"},    {31'd0, instr_done},    {31'd0, ed});
        chk({tag, ".count"},   {28'd0, instr_count},   {28'd0, exp_count});
        chk({tag, ".illegal"}, {31'd0, illegal},       {31'd0, exp_illegal});
        chk({tag, ".halted"},  {31'd0, halted},        {31'd0, exp_halted});
    endtask

    // One rising edge, then sample 1ns later.
    task automatic tick(input string tag, input logic [3:0] es, input logic ed);
        @(posedge clk);
        #1;
        chk_all(tag, es, ed);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #2;
        exp_count   = 4'd0;
        exp_illegal = 1'b0;
        exp_halted  = 1'b0;
        chk_all(tag, 4'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        opcode      = OP_R;
        mem_ready   = 1'b1;
        exp_count   = 4'd0;
        exp_illegal = 1'b0;
        exp_halted  = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("reset", 4'd0, 1'b0);
        rst_n = 1'b1;

        // R-type: 0,1,6,7,0
        tick("r.s1", 4'd1, 1'b0);
        tick("r.s6", 4'd6, 1'b0);
        tick("r.s7", 4'd7, 1'b0);
        exp_count = 4'd1;
        tick("r.s0", 4'd0, 1'b1);

        // LW: S3 for 4 cycles, mem_ready arrives on the last allowed wait cycle
        opcode    = OP_LW;
        mem_ready = 1'b0;
        tick("lw.s1", 4'd1, 1'b0);
        tick("lw.s2", 4'd2, 1'b0);
        tick("lw.s3a", 4'd3, 1'b0);
        tick("lw.s3b", 4'd3, 1'b0);
        tick("lw.s3c", 4'd3, 1'b0);
        tick("lw.s3d", 4'd3, 1'b0);
        mem_ready = 1'b1;
        tick("lw.s4", 4'd4, 1'b0);
        exp_count = 4'd2;
        tick("lw.s0", 4'd0, 1'b1);

        // SW, BEQ, J with mem_ready high
        opcode = OP_SW;
        tick("sw.s1", 4'd1, 1'b0);
        tick("sw.s2", 4'd2, 1'b0);
        tick("sw.s5", 4'd5, 1'b0);
        exp_count = 4'd3;
        tick("sw.s0", 4'd0, 1'b1);
        opcode = OP_BEQ;
        tick("beq.s1", 4'd1, 1'b0);
        tick("beq.s8", 4'd8, 1'b0);
        exp_count = 4'd4;
        tick("beq.s0", 4'd0, 1'b1);
        opcode = OP_J;
        tick("j.s1", 4'd1, 1'b0);
        tick("j.s9", 4'd9, 1'b0);
        exp_count = 4'd5;
        tick("j.s0", 4'd0, 1'b1);

        // Illegal opcode
        opcode = OP_BAD;
        tick("ill.s1", 4'd1, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        exp_illegal = 1'b1;
        exp_halted  = 1'b1;
        tick("ill.s15", 4'd15, 1'b0);
        tick("ill.hold", 4'd15, 1'b0);
`else
        exp_illegal = 1'b1;
        exp_count   = 4'd6;
        tick("ill.s0", 4'd0, 1'b1);
        opcode = OP_J;
        tick("ill.next", 4'd1, 1'b0);
`endif
        async_reset("rst1");

        // Timeout: SW with mem_ready held low -> S15 after 4 wait cycles
        opcode    = OP_SW;
        mem_ready = 1'b0;
        tick("to.s1", 4'd1, 1'b0);
        tick("to.s2", 4'd2, 1'b0);
        tick("to.s5a", 4'd5, 1'b0);
        tick("to.s5b", 4'd5, 1'b0);
        tick("to.s5c", 4'd5, 1'b0);
        tick("to.s5d", 4'd5, 1'b0);
        exp_halted = 1'b1;
        tick("to.s15", 4'd15, 1'b0);
        mem_ready = 1'b1;
        tick("to.hold", 4'd15, 1'b0);
        async_reset("rst_halt");

        // Reset in the middle of an LW wait
        opcode    = OP_LW;
        mem_ready = 1'b0;
        tick("mw.s1", 4'd1, 1'b0);
        tick("mw.s2", 4'd2, 1'b0);
        tick("mw.s3a", 4'd3, 1'b0);
        tick("mw.s3b", 4'd3, 1'b0);
        async_reset("rst_wait");

        // Wait counter must restart after reset: full 4-cycle LW wait completes
        mem_ready = 1'b0;
        tick("lw2.s1", 4'd1, 1'b0);
        tick("lw2.s2", 4'd2, 1'b0);
        tick("lw2.s3a", 4'd3, 1'b0);
        tick("lw2.s3b", 4'd3, 1'b0);
        tick("lw2.s3c", 4'd3, 1'b0);
        tick("lw2.s3d", 4'd3, 1'b0);
        mem_ready = 1'b1;
        tick("lw2.s4", 4'd4, 1'b0);
        exp_count = 4'd1;
        tick("lw2.s0", 4'd0, 1'b1);
        async_reset("rst_wrap");

        // 17 J instructions: 4-bit counter wraps to 1
        opcode    = OP_J;
        mem_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick("wrap.s1", 4'd1, 1'b0);
            tick("wrap.s9", 4'd9, 1'b0);
            exp_count = exp_count + 4'd1;
            tick("wrap.s0", 4'd0, 1'b1);
        end
        chk("wrap.final", {28'd0, instr_count}, 32'd1);
        tick("wrap.after", 4'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
